// File: rtl/fall_scheduler.sv
// Gravity/lock-delay sequencer: level from score, fall period selection, fall_tick pulses, lock_req/lock_ack handoff.
// Optional hard drop behind `HARD_DROP_EN` (adds hard_drop input); default build has no such port.
module fall_scheduler #(
  parameter int unsigned BASE_PERIOD = 10000000,
  parameter int unsigned STEP_DEC    = 1000000,
  parameter int unsigned MIN_PERIOD  = 1000000,
  parameter int unsigned SOFT_PERIOD = 500000,
  parameter int unsigned LOCK_TICKS  = 5000000,
  parameter int unsigned LEVEL_SHIFT = 2,
  parameter int unsigned MAX_LEVEL   = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  input  logic [11:0] score,
  input  logic        spawn,
  input  logic        soft_drop,
  input  logic        landed,
  input  logic        lock_ack,
`ifdef HARD_DROP_EN
  input  logic        hard_drop,
`endif
  output logic        fall_tick,
  output logic        lock_req,
  output logic [3:0]  level
);

  typedef enum logic [1:0] {IDLE, FALL, LAND, LOCK} state_t;

  localparam logic [35:0] SPAN      = 36'(BASE_PERIOD - MIN_PERIOD);
  localparam logic [31:0] LOCK_LAST = 32'(LOCK_TICKS - 1);

  state_t      state, state_n;
  logic [31:0] fall_cnt, fall_cnt_n;
  logic [31:0] lock_cnt, lock_cnt_n;
  logic        tick_n;
  logic        lock_req_n;
  logic [3:0]  level_n;

  logic [11:0] score_lvl;
  logic [3:0]  level_calc;
  logic [35:0] lvl_dec;
  logic [31:0] norm_period;
  logic [31:0] eff_period;
  logic [31:0] period_last;

  assign score_lvl  = score >> LEVEL_SHIFT;
  assign level_calc = (score_lvl > 12'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : score_lvl[3:0];

  // Floor check is done on the product so BASE - level*STEP can never underflow.
  assign lvl_dec     = 36'(level) * 36'(STEP_DEC);
  assign norm_period = (lvl_dec >= SPAN) ? 32'(MIN_PERIOD)
                                         : 32'(BASE_PERIOD) - lvl_dec[31:0];
  assign eff_period  = (soft_drop && (32'(SOFT_PERIOD) < norm_period)) ? 32'(SOFT_PERIOD)
                                                                       : norm_period;
  assign period_last = eff_period - 32'd1;

`ifdef HARD_DROP_EN
  logic drop, drop_n;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fall_cnt  <= '0;
      lock_cnt  <= '0;
      fall_tick <= 1'b0;
      lock_req  <= 1'b0;
      level     <= '0;
`ifdef HARD_DROP_EN
      drop      <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      fall_cnt  <= fall_cnt_n;
      lock_cnt  <= lock_cnt_n;
      fall_tick <= tick_n;
      lock_req  <= lock_req_n;
      level     <= level_n;
`ifdef HARD_DROP_EN
      drop      <= drop_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    fall_cnt_n = fall_cnt;
    lock_cnt_n = lock_cnt;
    tick_n     = 1'b0;
    lock_req_n = lock_req;
    level_n    = level;
`ifdef HARD_DROP_EN
    drop_n     = drop;
`endif
    if (!pause) begin
      level_n    = level_calc;
      // lock_req trails the LOCK state by one cycle, so it also drops one cycle after the ack.
      lock_req_n = (state == LOCK);
      case (state)
        IDLE: begin
          if (spawn) begin
            state_n    = FALL;
            fall_cnt_n = '0;
          end
        end
        FALL: begin
`ifdef HARD_DROP_EN
          if (drop || hard_drop) begin
            drop_n     = 1'b1;
            fall_cnt_n = '0;
            if (landed) begin
              state_n = LOCK;
              drop_n  = 1'b0;
            end else begin
              tick_n = 1'b1;
            end
          end else
`endif
          if (fall_cnt >= period_last) begin
            fall_cnt_n = '0;
            if (landed) begin
              state_n    = LAND;
              lock_cnt_n = '0;
            end else begin
              tick_n = 1'b1;
            end
          end else begin
            fall_cnt_n = fall_cnt + 32'd1;
          end
        end
        LAND: begin
          // An escape outranks a lock count completing in the same cycle.
          if (!landed) begin
            state_n    = FALL;
            fall_cnt_n = '0;
          end else if (lock_cnt == LOCK_LAST) begin
            state_n = LOCK;
          end else begin
            lock_cnt_n = lock_cnt + 32'd1;
          end
        end
        LOCK: begin
          if (lock_ack) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
